hq2x_ctrl: RTL and testbench
============================

HQ2X_CTRL -- requirements
Module: hq2x_ctrl

Interface
REQ-001 Parameter DEFAULT_PERIOD, 1364, input-line period in clk cycles when no measurement is available.
REQ-002 Parameter H_ACTIVE, 512, active output pixels per output line.
REQ-003 Parameter H_SYNC_START, 560 / H_SYNC_LEN, 64: output hsync window in output-x units.
REQ-004 Parameter V_ACTIVE, 480 / V_SYNC_START, 490 / V_SYNC_LEN, 2: output line counts.
REQ-005 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port in_frame_start, input, 1, one-clk pulse coinciding with in_line_start of the first input line.
REQ-009 Port in_line_start, input, 1, one-clk pulse at the start of each input line.
REQ-010 Port hq_frame_available, input, 1, scaler's frame-available flag.
REQ-011 Port reset_frame, output, 1, frame reset to the scaler.
REQ-012 Port reset_line, output, 1, line reset to the scaler.
REQ-013 Port read_x, output, 10, {subline, x[8:0]} read address to the scaler output buffer.
REQ-014 Ports out_hs, out_vs, out_de, output, 1 each, output video timing aligned to the scaler's outpixel.
REQ-015 Port line_err, output, 1, sticky flag: input line period exceeded 2047 clk.

Function
REQ-016 reset_line SHALL be high for exactly 2 clk, starting the clk after each in_line_start.
REQ-017 reset_frame SHALL be high for exactly 1 clk, starting the clk after in_frame_start, coincident with the first reset_line cycle.
REQ-018 FSM states SHALL be IDLE, WAIT_FA and RUN.
REQ-019 IDLE -> WAIT_FA on in_frame_start.
REQ-020 WAIT_FA -> RUN on the first in_line_start that follows hq_frame_available = 1.
REQ-021 RUN -> WAIT_FA on in_frame_start.
REQ-022 Period counter: 11 bits, cleared on in_line_start, saturates at 2047; on saturation line_err SHALL set and stay set until reset.
REQ-023 Half-period SHALL be HP = period >> 1, latched at each in_line_start.
REQ-024 In RUN, output x counter ox SHALL count 0..HP-1, then wrap to 0 and toggle subline.
REQ-025 Output line counter SHALL increment on every ox wrap and clear to 0 on the RUN entry edge.
REQ-026 An in_line_start arriving before the second subline completes SHALL force ox = 0 and subline = 0 on the next clk (resync, no error).
REQ-027 read_x SHALL equal {subline, ox[8:0]} while ox < H_ACTIVE, and 0 otherwise.
REQ-028 out_de SHALL be (ox < H_ACTIVE) && (oline < V_ACTIVE) && RUN.
REQ-029 out_hs SHALL be high for ox in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
REQ-030 out_vs SHALL be high for oline in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN).
REQ-031 out_hs, out_vs and out_de SHALL lag read_x by exactly 1 clk, matching the scaler's registered read.
REQ-032 Outside RUN, read_x, out_de, out_hs and out_vs SHALL be 0.
REQ-033 in_frame_start and in_line_start SHALL be treated as one frame-start event when simultaneous.
REQ-034 A pulse arriving while reset_line is still high SHALL restart the 2-clk window.

Reset
REQ-035 While reset = 1, all outputs SHALL be 0.
REQ-036 Reset SHALL set state IDLE, ox = 0, subline = 0, oline = 0, period = DEFAULT_PERIOD and clear line_err.
REQ-037 Reset asserted mid-line SHALL abort immediately; nothing resumes until the next in_frame_start.

Configuration
REQ-038 Macro HQ2X_CTRL_LINE_MEASURE_EN, when defined, SHALL enable the measured period per REQ-022/023.
REQ-039 When HQ2X_CTRL_LINE_MEASURE_EN is undefined, HP SHALL be fixed at DEFAULT_PERIOD >> 1.
REQ-040 When HQ2X_CTRL_LINE_MEASURE_EN is undefined, the period counter is removed and line_err SHALL be tied to 0.

Verification
REQ-041 Line starts every 1364 clk after frame start; hq_frame_available set on line 2 -> RUN at the 3rd line start; HP = 682; read_x[9] toggles every 682 clk.
REQ-042 In RUN -> read_x walks 0..511 then holds 0 for 170 clk; out_de rises 1 clk after read_x = 0 and is 512 clk wide.
REQ-043 Line period shortened to 1200 clk mid-frame -> HP = 600 from the following line; second subline truncated and resynced with no glitch on out_hs.
REQ-044 No line start for 2100 clk -> line_err = 1 and stays 1 through later normal lines; cleared only by reset.
REQ-045 reset pulsed for 1 clk during RUN -> all outputs 0 on the next clk; FSM IDLE; out_de stays 0 until in_frame_start plus frame-available.
REQ-046 Build without HQ2X_CTRL_LINE_MEASURE_EN and 1200-clk lines -> HP stays 682 and line_err stays 0.

Source files
------------

// File: rtl/hq2x_ctrl.sv
// hq2x_ctrl: input line/frame sequencing and 2x output video timing for the hq2x scaler.
// Define HQ2X_CTRL_LINE_MEASURE_EN to derive the output half-period from measured input lines.
module hq2x_ctrl #(
  parameter int unsigned DEFAULT_PERIOD = 1364,
  parameter int unsigned H_ACTIVE       = 512,
  parameter int unsigned H_SYNC_START   = 560,
  parameter int unsigned H_SYNC_LEN     = 64,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_SYNC_START   = 490,
  parameter int unsigned V_SYNC_LEN     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_frame_start,
  input  logic       in_line_start,
  input  logic       hq_frame_available,
  output logic       reset_frame,
  output logic       reset_line,
  output logic [9:0] read_x,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       line_err
);

  localparam logic [10:0] HActive    = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_SYNC_START);
  localparam logic [10:0] HSyncEnd   = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] VActive    = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncStart = 11'(V_SYNC_START);
  localparam logic [10:0] VSyncEnd   = 11'(V_SYNC_START + V_SYNC_LEN);

  typedef enum logic [1:0] {StIdle, StWaitFa, StRun} state_e;

  state_e      state_q, state_d;
  logic        frame_ev, line_ev, any_ev;
  logic        fa_seen_q;
  logic [1:0]  rl_cnt_q;
  logic        rf_q;
  logic [9:0]  hp;
  logic        err;
  logic [9:0]  ox_q;
  logic        sub_q;
  logic [10:0] oline_q;
  logic        de_q, hs_q, vs_q;
  logic        run, in_h, v_act, h_sync, v_sync, wrap;

  // A simultaneous frame and line pulse is a single frame-start event.
  assign frame_ev = in_frame_start;
  assign line_ev  = in_line_start & ~in_frame_start;
  assign any_ev   = in_line_start | in_frame_start;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (frame_ev) state_d = StWaitFa;
      StWaitFa: if (line_ev && fa_seen_q) state_d = StRun;
      StRun:    if (frame_ev) state_d = StWaitFa;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    run    = (state_q == StRun);
    in_h   = {1'b0, ox_q} < HActive;
    v_act  = oline_q < VActive;
    h_sync = ({1'b0, ox_q} >= HSyncStart) && ({1'b0, ox_q} < HSyncEnd);
    v_sync = (oline_q >= VSyncStart) && (oline_q < VSyncEnd);
    read_x = '0;
    if (run && in_h && !reset) read_x = {sub_q, ox_q[8:0]};
    out_de      = de_q & run & ~reset;
    out_hs      = hs_q & run & ~reset;
    out_vs      = vs_q & run & ~reset;
    reset_frame = rf_q & ~reset;
    reset_line  = (rl_cnt_q != 2'd0) & ~reset;
    line_err    = err & ~reset;
  end

  // Scaler resets; a new pulse reloads the 2-clk line-reset window.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q      <= 1'b0;
      rl_cnt_q  <= 2'd0;
      fa_seen_q <= 1'b0;
    end else begin
      rf_q <= frame_ev;
      if (any_ev)                rl_cnt_q <= 2'd2;
      else if (rl_cnt_q != 2'd0) rl_cnt_q <= rl_cnt_q - 2'd1;
      if (state_q != StWaitFa || frame_ev) fa_seen_q <= 1'b0;
      else if (hq_frame_available)         fa_seen_q <= 1'b1;
    end
  end

  assign wrap = ({1'b0, ox_q} + 11'd1) >= {1'b0, hp};

  // Output raster; a line start ending the second subline counts as that subline's wrap.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      ox_q    <= '0;
      sub_q   <= 1'b0;
      oline_q <= '0;
    end else if (any_ev) begin
      ox_q  <= '0;
      sub_q <= 1'b0;
      if (sub_q) oline_q <= oline_q + {10'd0, ~&oline_q};
    end else if (wrap) begin
      ox_q    <= '0;
      sub_q   <= ~sub_q;
      oline_q <= oline_q + {10'd0, ~&oline_q};
    end else begin
      ox_q <= ox_q + 10'd1;
    end
  end

  // Timing flags follow read_x by one clk to match the scaler's registered read.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= run && in_h && v_act;
      hs_q <= run && h_sync;
      vs_q <= run && v_sync;
    end
  end

`ifdef HQ2X_CTRL_LINE_MEASURE_EN
  localparam logic [10:0] PeriodRst = 11'(DEFAULT_PERIOD);

  logic [10:0] pcnt_q, period_q;
  logic        pvalid_q, err_q;

  // Period latches only once a previous line start gives a valid reference.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q   <= '0;
      period_q <= PeriodRst;
      pvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (any_ev) begin
        pcnt_q   <= '0;
        pvalid_q <= 1'b1;
        if (pvalid_q) period_q <= (&pcnt_q) ? pcnt_q : pcnt_q + 11'd1;
      end else if (!(&pcnt_q)) begin
        pcnt_q <= pcnt_q + 11'd1;
      end
      if (&pcnt_q) err_q <= 1'b1;
    end
  end

  assign hp  = period_q[10:1];
  assign err = err_q;
`else
  assign hp  = 10'(DEFAULT_PERIOD >> 1);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hq2x_ctrl.sv
// tb_hq2x_ctrl: table vectors, directed line sequences and randomized frames for hq2x_ctrl,
// all outputs compared every clk against an arithmetic reference model.
module tb_hq2x_ctrl;
  localparam int DP  = 1364;
  localparam int HA  = 512;
  localparam int HSS = 560;
  localparam int HSL = 64;
  localparam int VA  = 6;
  localparam int VSS = 7;
  localparam int VSL = 2;
`ifdef HQ2X_CTRL_LINE_MEASURE_EN
  localparam bit Measure = 1'b1;
`else
  localparam bit Measure = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_frame_start, in_line_start, hq_frame_available;
  logic       reset_frame, reset_line, out_hs, out_vs, out_de, line_err;
  logic [9:0] read_x;

  hq2x_ctrl #(
    .DEFAULT_PERIOD(DP), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .clk(clk), .reset(reset), .in_frame_start(in_frame_start), .in_line_start(in_line_start),
    .hq_frame_available(hq_frame_available), .reset_frame(reset_frame),
    .reset_line(reset_line), .read_x(read_x), .out_hs(out_hs), .out_vs(out_vs),
    .out_de(out_de), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 waiting for frame-available, 2 running.
  longint cyc = 0;
  int     m_mode = 0;
  bit     m_fa = 1'b0;
  longint m_seg_start = 0;
  int     m_seg_hp = DP / 2;
  int     m_base = 0;
  bit     m_err = 1'b0;
  longint m_last_ls = -10;
  longint m_origin = 0;
  bit     m_ls_valid = 1'b0;
  int     m_period = DP;
  bit     p_de = 1'b0, p_hs = 1'b0, p_vs = 1'b0, p_fs = 1'b0;

  // Observations of the DUT for directed checks.
  int     de_seen = 0;
  int     x200_cnt = 0;
  longint last_x200 = 0;
  longint line_t = 0;
  int     s_rf, s_rl, s_err, s_de, s_rx;

  typedef struct {
    bit rst; bit fs; bit ls; bit fa; bit rf; bit rl;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit r, input bit f, input bit l, input bit a);
    int     ox, nw, sub, ol, erx, hp;
    bit     run, cde, chs, cvs;
    longint k;
    reset = r; in_frame_start = f; in_line_start = l; hq_frame_available = a;
    if (l || f) line_t = cyc;
    run = (m_mode == 2);
    ox = 0; nw = 0; sub = 0; ol = 0;
    if (run) begin
      k   = cyc - m_seg_start - 1;
      ox  = int'(k % m_seg_hp);
      nw  = int'(k / m_seg_hp);
      sub = nw % 2;
      ol  = m_base + nw;
    end
    cde = run && ox < HA && ol < VA;
    chs = run && ox >= HSS && ox < HSS + HSL;
    cvs = run && ol >= VSS && ol < VSS + VSL;
    erx = (!r && run && ox < HA) ? sub * 512 + ox : 0;
    @(negedge clk);
    check("read_x", int'(read_x), erx);
    check("out_de", int'(out_de), int'(!r && run && p_de));
    check("out_hs", int'(out_hs), int'(!r && run && p_hs));
    check("out_vs", int'(out_vs), int'(!r && run && p_vs));
    check("reset_frame", int'(reset_frame), int'(!r && p_fs));
    check("reset_line", int'(reset_line),
          int'(!r && (cyc - m_last_ls == 1 || cyc - m_last_ls == 2)));
    check("line_err", int'(line_err), int'(!r && m_err));
    if (out_de) de_seen++;
    if (read_x == 10'h200) begin
      x200_cnt++;
      last_x200 = cyc;
    end
    s_rf = int'(reset_frame); s_rl = int'(reset_line); s_err = int'(line_err);
    s_de = int'(out_de); s_rx = int'(read_x);
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_fa = 1'b0; m_last_ls = cyc - 10; m_origin = cyc; m_ls_valid = 1'b0;
      m_period = DP; m_err = 1'b0; p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_fs = 1'b0;
    end else begin
      if (Measure && cyc - m_origin - 1 >= 2047) m_err = 1'b1;
      p_de = cde; p_hs = chs; p_vs = cvs; p_fs = f;
      if (l || f) begin
        if (Measure && m_ls_valid)
          m_period = (cyc - m_origin > 2047) ? 2047 : int'(cyc - m_origin);
        m_origin = cyc; m_ls_valid = 1'b1; m_last_ls = cyc;
      end
      hp = Measure ? m_period / 2 : DP / 2;
      case (m_mode)
        0: if (f) begin m_mode = 1; m_fa = 1'b0; end
        1: begin
          if (f) m_fa = 1'b0;
          else if (l && m_fa) begin
            m_mode = 2; m_seg_start = cyc; m_seg_hp = hp; m_base = 0;
          end else if (a) m_fa = 1'b1;
        end
        default: begin
          if (f) begin
            m_mode = 1; m_fa = 1'b0;
          end else if (l) begin
            nw = int'((cyc - m_seg_start - 1) / m_seg_hp);
            m_base = m_base + nw + nw % 2;
            m_seg_start = cyc; m_seg_hp = hp;
          end
        end
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic line(input int len, input bit frame, input bit fa, input int rst_at);
    for (int i = 0; i < len; i++) cycle(i == rst_at, frame && i == 0, i == 0, fa);
  endtask

  initial begin
    int nlines, fa_line, len, rst_at;
    reset = 1'b1; in_frame_start = 1'b0; in_line_start = 1'b0; hq_frame_available = 1'b0;
    @(posedge clk);
    #1;

    // {rst, fs, ls, fa, expected reset_frame, expected reset_line}
    tbl = '{
      '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, '{0, 1, 1, 0, 0, 0}, '{0, 0, 0, 0, 1, 1},
      '{0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}, '{0, 0, 1, 0, 0, 1},
      '{0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}
    };
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].fs, tbl[i].ls, tbl[i].fa);
      check("tbl_reset_frame", s_rf, int'(tbl[i].rf));
      check("tbl_reset_line", s_rl, int'(tbl[i].rl));
    end

    // Nominal frame: frame-available during line 2, RUN from the 3rd line start.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    line(DP, 1, 0, -1);
    line(DP, 0, 1, -1);
    check("de_before_run", de_seen, 0);
    de_seen = 0;
    x200_cnt = 0;
    line(DP, 0, 1, -1);
    line(DP, 0, 1, -1);
    check("de_width_two_lines", de_seen, 4 * HA);
    check("subline1_starts", x200_cnt, 2);
    check("subline1_offset", int'(last_x200 - line_t), DP / 2 + 1);

    // Shortened line: measured build adopts HP = 600 on the following line.
    line(1200, 0, 1, -1);
    line(DP, 0, 1, -1);
    check("hp_after_short", int'(last_x200 - line_t), Measure ? 601 : DP / 2 + 1);

    // Missing line start: sticky error in the measured build only.
    line(2100, 0, 1, -1);
    check("line_err_long", s_err, int'(Measure));
    line(DP, 0, 1, -1);
    line(DP, 0, 1, -1);
    check("line_err_sticky", s_err, int'(Measure));

    // Reset pulse mid-RUN, then no output until a new frame start.
    line(DP, 1, 1, -1);
    line(700, 0, 1, -1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("rx_after_reset", s_rx, 0);
    check("de_after_reset", s_de, 0);
    check("err_after_reset", s_err, 0);
    de_seen = 0;
    line(DP, 0, 1, -1);
    line(DP, 0, 1, -1);
    check("no_de_without_frame", de_seen, 0);

    // Randomized frames with varying line periods, stalls and occasional resets.
    for (int f = 0; f < 6; f++) begin
      nlines  = int'($urandom_range(3, 7));
      fa_line = int'($urandom_range(0, 2));
      for (int ln = 0; ln < nlines; ln++) begin
        len    = ($urandom_range(0, 9) == 0) ? 2100 : int'($urandom_range(600, 1500));
        rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        line(len, ln == 0, ln >= fa_line, rst_at);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
